// File: rtl/jtframe_db15_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_db15_pkg
// Purpose : Shared types and constants for the DB15 arcade-stick scanner.
//           Holds the scan FSM state encoding and the bit positions of the
//           directions/buttons inside each published joystick word.
// Ports   : none (package)
// Config  : JTFRAME_DB15_DEBOUNCE_EN is consumed by jtframe_db15_scan only.
// Revision: 1.0  initial release
// ============================================================================
package jtframe_db15_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SH_HI = 3'd2,
        SH_LO = 3'd3,
        DONE  = 3'd4
    } db15_state_t;

    // Bit positions inside each player's half-frame
    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int BTN0  = 4;

endpackage
`default_nettype wire

// File: rtl/jtframe_db15_tick.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_db15_tick
// Purpose : Prescaler for the DB15 scanner. Counts 0..DIV-1 and raises a
//           one-cycle tick while the count sits at DIV-1, so the first tick
//           is acted upon DIV cycles after reset is released.
// Ports   : clk_sys  in  system clock
//           rst      in  synchronous active-high reset (clears the count)
//           tick_o   out one-cycle strobe, period DIV cycles
// Params  : DIV  cycles per tick, min 2
// Revision: 1.0  initial release
// ============================================================================
import jtframe_db15_pkg::*;

module jtframe_db15_tick #(
    parameter int DIV = 16
) (
    input  logic clk_sys,
    input  logic rst,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CW'(DIV - 1));

endmodule
`default_nettype wire

// File: rtl/jtframe_db15_scan.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_db15_scan
// Purpose : Serial reader for the DB15 arcade-stick adapter (two chained
//           74HC165). Generates JOY_LOAD/JOY_CLK, samples JOY_DATA and
//           publishes two active-high 16-bit joystick words.
// Ports   : clk_sys     in   system clock
//           rst         in   synchronous active-high reset
//           JOY_DATA    in   serial data, active-low buttons, asynchronous
//           JOY_CLK     out  shift clock to the adapter
//           JOY_LOAD    out  parallel load, active-low
//           joystick1   out  player 1 word, bits [NBITS/2-1:0] valid
//           joystick2   out  player 2 word, same layout
//           frame_done  out  one-cycle strobe after each captured frame
// Params  : DIV (cycles per tick, min 2), NBITS (even, max 32),
//           GAP (idle ticks between frames, min 1)
// Config  : JTFRAME_DB15_DEBOUNCE_EN - when defined, a frame is published
//           only if it matches the previous raw frame.
// Revision: 1.0  initial release
// ============================================================================
import jtframe_db15_pkg::*;

module jtframe_db15_scan #(
    parameter int DIV   = 16,
    parameter int NBITS = 24,
    parameter int GAP   = 15
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam int IW   = $clog2(NBITS);
    localparam int GW   = $clog2(GAP + 1);
    localparam int HALF = NBITS / 2;

    logic              tick;
    logic [1:0]        sync_q;
    db15_state_t       state_q;
    logic [GW-1:0]     gap_q;
    logic [IW-1:0]     idx_q;
    logic [NBITS-1:0]  raw_q;
    logic              joy_clk_q;
    logic              joy_load_q;
    logic [15:0]       joy1_q;
    logic [15:0]       joy2_q;
    logic              frame_done_q;
    logic [15:0]       joy1_d;
    logic [15:0]       joy2_d;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
    logic [NBITS-1:0]  prev_raw_q;
`endif

    jtframe_db15_tick #(
        .DIV    (DIV)
    ) u_tick (
        .clk_sys(clk_sys),
        .rst    (rst),
        .tick_o (tick)
    );

    // Idle level of the line is high (no button pressed), so the
    // synchroniser resets to ones to avoid a spurious "pressed" sample.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], JOY_DATA};
        end
    end

    // Candidate words for publication: low half to player 1, high half to 2
    assign joy1_d = 16'(raw_q[HALF-1:0]);
    assign joy2_d = 16'(raw_q[NBITS-1:HALF]);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= IDLE;
            // Preloaded so the very first tick out of reset starts a frame
            gap_q        <= GW'(GAP - 1);
            idx_q        <= '0;
            raw_q        <= '0;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            joy1_q       <= '0;
            joy2_q       <= '0;
            frame_done_q <= 1'b0;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
            prev_raw_q   <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        joy_clk_q  <= 1'b0;
                        if (gap_q == GW'(GAP - 1)) begin
                            gap_q      <= '0;
                            joy_load_q <= 1'b0;
                            state_q    <= LOAD;
                        end else begin
                            gap_q      <= gap_q + 1'b1;
                        end
                    end
                    LOAD: begin
                        joy_load_q <= 1'b1;
                        idx_q      <= '0;
                        state_q    <= SH_HI;
                    end
                    SH_HI: begin
                        // Bit idx is already on the line: sample, then shift
                        raw_q[idx_q] <= ~sync_q[1];
                        joy_clk_q    <= 1'b1;
                        state_q      <= SH_LO;
                    end
                    SH_LO: begin
                        joy_clk_q <= 1'b0;
                        if (idx_q == IW'(NBITS - 1)) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SH_HI;
                        end
                    end
                    DONE: begin
                        frame_done_q <= 1'b1;
                        gap_q        <= '0;
                        state_q      <= IDLE;
`ifdef JTFRAME_DB15_DEBOUNCE_EN
                        // Two identical consecutive frames are required
                        prev_raw_q   <= raw_q;
                        if (raw_q == prev_raw_q) begin
                            joy1_q <= joy1_d;
                            joy2_q <= joy2_d;
                        end
`else
                        joy1_q       <= joy1_d;
                        joy2_q       <= joy2_d;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign JOY_CLK    = joy_clk_q;
    assign JOY_LOAD   = joy_load_q;
    assign joystick1  = joy1_q;
    assign joystick2  = joy2_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
